uart_rx_fifo: RTL and testbench

Receive buffer for the UART receiver. It captures each byte that the receive datapath transfers into its data register and holds up to `depth` bytes. Bytes are presented first-word-fall-through on a valid/ready read port to the host side. Occupancy, full and empty status are reported, along with a sticky overrun flag for bytes dropped while the buffer is full.

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 71 +++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - write, read and status bundle for the UART receive buffer
interface uart_rx_fifo_if #(
  parameter int word_size = 8,
  parameter int addr_bits = 3
);
  logic [word_size-1:0] data_in;
  logic                 write;
  logic [word_size-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [addr_bits:0]   count;
  logic                 full;
  logic                 empty;
  logic                 overrun;
  logic                 clr_overrun;
  logic                 flush;

  modport master (
    output data_in, write, rd_ready, clr_overrun, flush,
    input  rd_data, rd_valid, count, full, empty, overrun
  );

  modport slave (
    input  data_in, write, rd_ready, clr_overrun, flush,
    output rd_data, rd_valid, count, full, empty, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive byte buffer with occupancy, flush and sticky overrun
module uart_rx_fifo #(
  parameter int word_size = 8,
  parameter int depth     = 8,
  parameter int addr_bits = 3
) (
  input  logic           clk,
  input  logic           rstn,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [addr_bits:0] full_cnt = (addr_bits + 1)'(depth);

  logic [word_size-1:0] mem [depth];
  logic [addr_bits-1:0] wp;
  logic [addr_bits-1:0] rp;
  logic [addr_bits:0]   cnt;
  logic                 ovr;

  logic is_full;
  logic is_empty;
  logic rd_ok;
  logic wr_ok;
  logic drop;

  assign is_full  = (cnt == full_cnt);
  assign is_empty = (cnt == '0);
  assign rd_ok    = !is_empty && bus.rd_ready;
  // A read in the same cycle frees a slot, so a full buffer still accepts the write.
  assign wr_ok    = bus.write && (!is_full || rd_ok);
  assign drop     = bus.write && is_full && !rd_ok && !bus.flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= bus.data_in;
        wp      <= wp + 1'b1;
      end
      if (rd_ok) rp <= rp + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Set beats clear; flush leaves the flag alone (drop is already masked by flush).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                ovr <= 1'b0;
    else if (drop)            ovr <= 1'b1;
    else if (bus.clr_overrun) ovr <= 1'b0;
  end

  assign bus.rd_data  = mem[rp];
  assign bus.rd_valid = !is_empty;
  assign bus.count    = cnt;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.overrun  = ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;

  uart_rx_fifo_if #(.word_size(8), .addr_bits(3)) bus ();

  uart_rx_fifo #(.word_size(8), .depth(8), .addr_bits(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.data_in = d;
    bus.write   = 1'b1;
    tick();
    bus.write   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},   32'(bus.count),    0);
    check({tag, "_empty"},   32'(bus.empty),    1);
    check({tag, "_full"},    32'(bus.full),     0);
    check({tag, "_valid"},   32'(bus.rd_valid), 0);
    check({tag, "_overrun"}, 32'(bus.overrun),  0);
    check({tag, "_rd_data"}, 32'(bus.rd_data),  0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn            = 1'b0;
    bus.data_in     = '0;
    bus.write       = 1'b0;
    bus.rd_ready    = 1'b0;
    bus.clr_overrun = 1'b0;
    bus.flush       = 1'b0;
    tick();
    tick();
    check_reset_state("rst");
    rstn = 1'b1;
    tick();

    // Three bytes in, then read back in order
    wr(8'h41);
    wr(8'h42);
    wr(8'h43);
    check("t1_count", 32'(bus.count), 3);
    check("t1_head", 32'(bus.rd_data), 32'h41);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_valid", 32'(bus.rd_valid), 1);
      check("t1_rd", 32'(bus.rd_data), 32'h41 + i);
      tick();
    end
    bus.rd_ready = 1'b0;
    check("t1_empty", 32'(bus.empty), 1);
    check("t1_count0", 32'(bus.count), 0);

    // Fill, drop on full, drain
    for (int i = 0; i < 8; i++) wr(8'(i));
    check("t2_full", 32'(bus.full), 1);
    check("t2_count8", 32'(bus.count), 8);
    wr(8'hAA);
    check("t2_overrun", 32'(bus.overrun), 1);
    check("t2_count_keep", 32'(bus.count), 8);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_rd", 32'(bus.rd_data), i);
      tick();
    end
    bus.rd_ready = 1'b0;
    check("t2_empty", 32'(bus.empty), 1);
    check("t2_ovr_sticky", 32'(bus.overrun), 1);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    check("t2_ovr_clr", 32'(bus.overrun), 0);

    // Write into a full buffer with a simultaneous read
    for (int i = 0; i < 8; i++) wr(8'(i));
    bus.rd_ready = 1'b1;
    wr(8'h55);
    bus.rd_ready = 1'b0;
    check("t3_count", 32'(bus.count), 8);
    check("t3_overrun", 32'(bus.overrun), 0);
    bus.rd_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("t3_rd", 32'(bus.rd_data), i);
      tick();
    end
    check("t3_rd_last", 32'(bus.rd_data), 32'h55);
    tick();
    bus.rd_ready = 1'b0;
    check("t3_empty", 32'(bus.empty), 1);

    // Streaming write+read every cycle, pointers wrap repeatedly
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr(8'(8'h10 + i));
      check("t4_rd", 32'(bus.rd_data), 32'h10 + i);
      check("t4_count", 32'(bus.count), 1);
    end
    tick();
    bus.rd_ready = 1'b0;
    check("t4_empty", 32'(bus.empty), 1);

    // Drop and clear in the same cycle: set wins
    for (int i = 0; i < 8; i++) wr(8'(i));
    bus.clr_overrun = 1'b1;
    wr(8'hAA);
    bus.clr_overrun = 1'b0;
    check("t5_set_wins", 32'(bus.overrun), 1);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    check("t5_clr", 32'(bus.overrun), 0);

    // Write into full buffer during flush must not set overrun
    bus.flush = 1'b1;
    wr(8'hEE);
    bus.flush = 1'b0;
    check("t6_flush_count", 32'(bus.count), 0);
    check("t6_flush_noovr", 32'(bus.overrun), 0);

    // Flush with write, overrun preserved
    for (int i = 0; i < 8; i++) wr(8'(i));
    wr(8'hAA);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
    check("t6_count5", 32'(bus.count), 5);
    bus.flush = 1'b1;
    wr(8'h77);
    bus.flush = 1'b0;
    check("t6_count0", 32'(bus.count), 0);
    check("t6_empty", 32'(bus.empty), 1);
    check("t6_valid", 32'(bus.rd_valid), 0);
    check("t6_ovr_keep", 32'(bus.overrun), 1);

    // Asynchronous reset mid-stream
    wr(8'h99);
    wr(8'h9A);
    check("t7_pre_count", 32'(bus.count), 2);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_state("t7");
    tick();
    rstn = 1'b1;
    tick();
    check_reset_state("t7_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
